mtx_job_issuer: RTL
===================

# mtx_job_issuer

Initiator-side controller for the 3x3 matrix multiply unit `mtx_mul_unit`. It accepts an element-serial job stream (9 elements of A, then 9 of B), assembles the flattened operands, and drives `start`. It then waits for `done`, captures C, and streams the 9 results out with backpressure. It is the block that drives `mtx_mul_unit` from the system side, in place of the class-based bench driver.

## Interface
Parameters:
- DATA_W, 8, width of one A/B element, unsigned.
- ACC_W, 2*DATA_W+2, width of one C element, unsigned.
- TIMEOUT, 64, maximum number of WAIT cycles before abort.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  job element valid.
- in_ready  out  1  job element ready.
- in_data  in  DATA_W  job element.
- out_valid  out  1  result element valid.
- out_ready  in  1  result element ready.
- out_data  out  ACC_W  result element.
- out_last  out  1  high with the 9th result element.
- start  out  1  one-cycle start pulse to `mtx_mul_unit`.
- A  out  9*DATA_W  flattened A operand to `mtx_mul_unit`.
- B  out  9*DATA_W  flattened B operand to `mtx_mul_unit`.
- C  in  9*ACC_W  flattened product from `mtx_mul_unit`.
- done  in  1  completion from `mtx_mul_unit`.
- busy  out  1  high in every state except LOAD.
- timeout_err  out  1  sticky abort flag.

## Operation
- Packing: element (r,c) sits at bits [(3r+c)*W +: W] of A, B and C. All three are row-major.
- Job stream order: A(0,0)…A(2,2), then B(0,0)…B(2,2).
- State LOAD:
  - `in_ready = (state==LOAD) && !rst`.
  - Each handshake writes in_data into slot `ld_cnt` (0..17) and increments `ld_cnt`.
  - Slot 17 accepted -> go to START, and `ld_cnt` clears.
- State START:
  - `start`=1 for exactly this cycle.
  - Go to WAIT; the timeout counter clears.
- State WAIT:
  - The timeout counter increments every cycle.
  - The first cycle with `done`=1 latches C into the result register, then go to DRAIN.
  - If the counter reaches TIMEOUT without `done`:
    - Set `timeout_err`.
    - Discard the job and return to LOAD.
    - Emit no output.
  - If `done` and expiry occur in the same cycle, `done` wins.
- State DRAIN:
  - `out_valid`=1 and `out_data` = result element `dr_cnt`.
  - On each `out_valid && out_ready` handshake, `dr_cnt` increments.
  - `out_last = (dr_cnt==8)`.
  - A handshake with `out_last` -> return to LOAD, and `dr_cnt` clears.
- `done` is ignored outside WAIT.
- `A` and `B` are driven straight from the operand registers. They are stable from START until the state leaves DRAIN.
- `timeout_err` stays high until `rst`; subsequent jobs still run normally.
- Reset, at any state including mid-WAIT and mid-DRAIN:
  - State goes to LOAD, and all counters and the result register clear.
  - `start`, `out_valid`, `out_last`, `busy` and `timeout_err` = 0; `out_data`, `A` and `B` = 0.
  - In-flight data is dropped.
  - A `done` that arrives late from the old job is ignored, because the state is LOAD.
- ACC_W must be at least 2*DATA_W+2 so the worst-case dot product (3·(2^DATA_W−1)^2) fits. No truncation or saturation.

## Timing
- Load: 18 accepted handshakes. `start` is asserted in the cycle after the 18th handshake.
- WAIT: the latency of `mtx_mul_unit`, plus 0 cycles to capture. `out_valid` rises in the cycle after the first `done`=1 cycle.
- Drain: one element per cycle at full throughput. `out_valid` and `out_data` hold stable while `out_ready`=0.
- LOAD: `in_ready` rises in the cycle after the final output handshake.
- Minimum job period: 18 + 1 + latency + 9 + 1 cycles.
- Every output is registered except `in_ready`, `busy` and `out_last`, which are decodes of the state and counters.

## Structure
- Shared package `mtx_pkg` holds:
  - `DIM=3` and `NUM_EL=9`.
  - The state enum `mtx_iss_state_t` {LOAD, START, WAIT, DRAIN}.
  - The function `acc_w(data_w)`.
  - The helper `el_idx(r,c)`.
- `mtx_mul_unit` imports the same package, so the packing is defined once.
- One sub-module: `mtx_result_serializer`. It holds the C capture register, `dr_cnt`, the out_valid/out_ready logic and `out_last`.
- The top level holds the FSM, the load counter, the operand registers and the timeout counter.

## Test plan
- Identity A, B = 1..9 row-major, `done` 3 cycles after `start` -> outputs 1..9, `out_last` on the 9th, exactly one `start` pulse.
- A = B = all 255, DATA_W=8 -> nine outputs of 195075.
- Random A/B with `out_ready` toggling 1,0,0,1… -> `out_data` is stable while stalled, order is preserved, and results match a reference model.
- `done` held low -> `timeout_err`=1 after 64 WAIT cycles, no `out_valid`, return to LOAD, and the next job completes correctly with `timeout_err` still 1.
- `rst` asserted mid-WAIT, then `done` pulsed -> no output, `in_ready`=1 once `rst` deasserts, all outputs 0.
- `done` pulsed during LOAD and DRAIN -> ignored, with no state change and no recapture of C.

Source files
------------

// File: rtl/mtx_pkg.sv
// Shared definitions for the 3x3 matrix multiply datapath and its job issuer.
// Element (r,c) of every flattened operand/result lives at slot el_idx(r,c).
package mtx_pkg;

  localparam int DIM    = 3;
  localparam int NUM_EL = DIM * DIM;

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT,
    DRAIN
  } mtx_iss_state_t;

  // Minimum accumulator width that holds 3*(2^data_w-1)^2 without overflow.
  function automatic int acc_w(input int data_w);
    return 2 * data_w + 2;
  endfunction

  // Row-major slot of element (r,c).
  function automatic int el_idx(input int r, input int c);
    return DIM * r + c;
  endfunction

endpackage

// File: rtl/mtx_result_serializer.sv
// Captures the flattened product C once and streams its nine elements out
// in row-major order under valid/ready backpressure.
module mtx_result_serializer
  import mtx_pkg::*;
#(
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    capture_i,
  input  logic [NUM_EL*ACC_W-1:0] c_i,
  input  logic                    out_ready_i,
  output logic                    out_valid_o,
  output logic [ACC_W-1:0]        out_data_o,
  output logic                    out_last_o,
  output logic                    drain_done_o
);

  logic [ACC_W-1:0] c_q [NUM_EL];
  logic [3:0]       dr_cnt_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_data_q;

  // Capture C on the done cycle, then advance one element per handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the result register is reset explicitly so a dropped job
      // leaves nothing readable behind; this is a small register file, not RAM.
      for (int i = 0; i < NUM_EL; i++) c_q[i] <= '0;
      dr_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (capture_i) begin
      for (int i = 0; i < NUM_EL; i++) c_q[i] <= c_i[i*ACC_W +: ACC_W];
      dr_cnt_q    <= '0;
      out_valid_q <= 1'b1;
      out_data_q  <= c_i[ACC_W-1:0];
    end else if (out_valid_q && out_ready_i) begin
      if (out_last_o) begin
        dr_cnt_q    <= '0;
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        dr_cnt_q   <= dr_cnt_q + 4'd1;
        out_data_q <= c_q[dr_cnt_q + 4'd1];
      end
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_last_o   = out_valid_q && (dr_cnt_q == 4'(NUM_EL - 1));
  assign drain_done_o = out_valid_q && out_ready_i && out_last_o;

endmodule

// File: rtl/mtx_job_issuer.sv
// Initiator-side controller for mtx_mul_unit: loads 18 serial elements
// (A then B), pulses start, waits for done with a timeout, then hands the
// captured product to the result serializer.
module mtx_job_issuer
  import mtx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = acc_w(DATA_W),
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic                     out_last,
  output logic                     start,
  output logic [NUM_EL*DATA_W-1:0] A,
  output logic [NUM_EL*DATA_W-1:0] B,
  input  logic [NUM_EL*ACC_W-1:0]  C,
  input  logic                     done,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int LD_W = $clog2(2 * NUM_EL);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [LD_W-1:0] LD_LAST = LD_W'(2 * NUM_EL - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  mtx_iss_state_t   state_q;
  logic [LD_W-1:0]  ld_cnt_q;
  logic [TO_W-1:0]  tmo_q;
  logic             start_q;
  logic             timeout_err_q;
  logic [DATA_W-1:0] op_q [2*NUM_EL];

  logic capture;
  logic drain_done;

  assign in_ready = (state_q == LOAD) && !rst;
  assign busy     = (state_q != LOAD);
  assign capture  = (state_q == WAIT) && done;

  // Job sequencing: load slots, pulse start, wait for done or timeout, drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOAD;
      ld_cnt_q      <= '0;
      tmo_q         <= '0;
      start_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      for (int i = 0; i < 2 * NUM_EL; i++) op_q[i] <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      start_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            op_q[ld_cnt_q] <= in_data;
            if (ld_cnt_q == LD_LAST) begin
              ld_cnt_q <= '0;
              start_q  <= 1'b1;
              state_q  <= START;
            end else begin
              ld_cnt_q <= ld_cnt_q + LD_W'(1);
            end
          end
        end
        START: begin
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A done on the final allowed cycle still completes the job.
          if (done) begin
            state_q <= DRAIN;
          end else if (tmo_q == TO_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= LOAD;
          end else begin
            tmo_q <= tmo_q + TO_W'(1);
          end
        end
        DRAIN: begin
          if (drain_done) state_q <= LOAD;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  // Flatten the operand slots row-major onto the A and B buses.
  always_comb begin
    // NOTE: defaults first so no path through the block can infer a latch.
    A = '0;
    B = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        A[el_idx(r, c)*DATA_W +: DATA_W] = op_q[el_idx(r, c)];
        B[el_idx(r, c)*DATA_W +: DATA_W] = op_q[NUM_EL + el_idx(r, c)];
      end
    end
  end

  assign start       = start_q;
  assign timeout_err = timeout_err_q;

  mtx_result_serializer #(
    .ACC_W(ACC_W)
  ) u_serializer (
    .clk         (clk),
    .rst         (rst),
    .capture_i   (capture),
    .c_i         (C),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .drain_done_o(drain_done)
  );

endmodule
